// File: rtl/timer_poll_master.sv
// timer_poll_master
// Bus initiator that drives the interval-timer peripheral in place of a CPU.
// It writes the start bit to the timer control register, waits for the
// peripheral to clear the register, then waits for the done bit. Each expiry
// produces a one-cycle tick, bumps tick_count and toggles led. In continuous
// mode the timer is re-armed after each expiry until stop is seen.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start, continuous start request (IDLE/ERROR only) and re-arm mode
//   stop              clears the re-arm latch; current period still ticks
//   address, Dataout  bus address / write data
//   WE                write enable, high for one cycle per arm
//   Datain            read data from the control register
//   busy              high outside IDLE and ERROR
//   tick, tick_count  expiry pulse and wrapping expiry count
//   led               toggles on each tick
//   error             set when the peripheral never clears after an arm
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for start
// WRITE_START | WE high, writing the start bit
// RELEASE     | WE low so the peripheral may clear; timeout counter reset
// WAIT_CLEAR  | polling for control[1:0]==00; bounded by CLEAR_TIMEOUT
// WAIT_DONE   | polling for control[1]==1 (no bound, periods are long)
// DONE        | tick; re-arm or go idle
// ERROR       | clear never seen; error held until the next start

module timer_poll_master #(
   parameter logic [31:0] TIMER_ADDR    = 32'h10C,
   parameter int          CLEAR_TIMEOUT = 16,
   parameter int          CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             stop,
   output logic [31:0]      address,
   output logic [31:0]      Dataout,
   output logic             WE,
   input  logic [31:0]      Datain,
   output logic             busy,
   output logic             tick,
   output logic [CNT_W-1:0] tick_count,
   output logic             led,
   output logic             error
);

   localparam int TO_W = $clog2(CLEAR_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE_START,
      S_RELEASE,
      S_WAIT_CLEAR,
      S_WAIT_DONE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic              run_q, run_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [31:0]       address_q, dataout_q;
   logic              we_q, busy_q, tick_q, led_q, error_q;
   logic [CNT_W-1:0]  tick_count_q;
   logic              busy_state;
   logic              rest_d;

   // Only the two flag bits of the control register are meaningful.
   logic unused_datain;
   assign unused_datain = ^Datain[31:2];

   assign busy_state = (state_q != S_IDLE) && (state_q != S_ERROR);

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
         S_IDLE, S_ERROR: begin
            if (start) begin
               state_d = S_WRITE_START;
               run_d   = continuous;
            end
         end
         S_WRITE_START: state_d = S_RELEASE;
         S_RELEASE: begin
            to_cnt_d = '0;
            state_d  = S_WAIT_CLEAR;
         end
         S_WAIT_CLEAR: begin
            // An X on the flags fails the equality and counts as not cleared.
            if (Datain[1:0] == 2'b00) begin
               state_d = S_WAIT_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_d == TO_W'(CLEAR_TIMEOUT)) state_d = S_ERROR;
            end
         end
         S_WAIT_DONE: begin
            // An X on bit1 does not take the if-branch, i.e. treated as not done.
            if (Datain[1] == 1'b1) state_d = S_DONE;
         end
         S_DONE: state_d = (run_q && !stop) ? S_WRITE_START : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (busy_state && stop) run_d = 1'b0;
   end

   assign rest_d = (state_d == S_IDLE) || (state_d == S_ERROR);

   // Outputs are registered from the next state so they line up with the
   // state they describe (start seen in IDLE gives WE one cycle later).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         run_q        <= 1'b0;
         to_cnt_q     <= '0;
         address_q    <= '0;
         dataout_q    <= '0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         tick_q       <= 1'b0;
         tick_count_q <= '0;
         led_q        <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         to_cnt_q  <= to_cnt_d;
         address_q <= rest_d ? 32'h0 : TIMER_ADDR;
         we_q      <= (state_d == S_WRITE_START);
         dataout_q <= (state_d == S_WRITE_START) ? 32'h1 : 32'h0;
         busy_q    <= !rest_d;
         tick_q    <= (state_d == S_DONE);
         error_q   <= (state_d == S_ERROR);
         if (state_d == S_DONE) begin
            tick_count_q <= tick_count_q + CNT_W'(1);
            led_q        <= ~led_q;
         end
      end
   end

   assign address    = address_q;
   assign Dataout    = dataout_q;
   assign WE         = we_q;
   assign busy       = busy_q;
   assign tick       = tick_q;
   assign tick_count = tick_count_q;
   assign led        = led_q;
   assign error      = error_q;

endmodule

// File: doc/timer_poll_master.md
Name: timer_poll_master

Overview:
- Bus initiator for the memory-mapped interval-timer peripheral. Its control register is at 0x10C: bit0 = start, bit1 = done.
- Writes the start bit, then polls the control register:
  - first for the peripheral's clear (bits[1:0]==00),
  - then for done (bit1==1).
- On each expiry: emits a tick pulse, increments a tick counter and toggles an LED.
- Sits in place of the CPU for standalone timer operation. Supports one-shot and continuous modes.

Parameters:
- TIMER_ADDR, 32'h10C, address of the timer control register.
- CLEAR_TIMEOUT, 16, max cycles in WAIT_CLEAR before error.
- CNT_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request to start; sampled in IDLE and ERROR only.
- continuous  in  1  sampled with start; 1 = re-arm after every expiry.
- stop  in  1  clears the continuous latch; takes effect at next DONE.
- address  out  32  bus address.
- Dataout  out  32  write data to the peripheral.
- WE  out  1  write enable, active high.
- Datain  in  32  read data from the peripheral; valid only while address==TIMER_ADDR.
- busy  out  1  high in every state except IDLE and ERROR.
- tick  out  1  one-cycle pulse per timer expiry.
- tick_count  out  CNT_W  expiry count; wraps modulo 2^CNT_W.
- led  out  1  toggles on every tick.
- error  out  1  sticky; set on clear timeout.

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE; address=0, Dataout=0, WE=0.
  - tick=0, tick_count=0, led=0, error=0, run latch=0, timeout counter=0.
- All outputs are registered.
- address=TIMER_ADDR in WRITE_START, RELEASE, WAIT_CLEAR, WAIT_DONE and DONE; 0 in IDLE and ERROR.
- States:
  - IDLE: if start==1 → WRITE_START; run latch <= continuous.
  - WRITE_START (1 cycle): WE=1, Dataout=32'h1 → RELEASE.
  - RELEASE (1 cycle): WE=0, Dataout=0; clear timeout counter → WAIT_CLEAR.
  - WAIT_CLEAR:
    - if Datain[1:0]==2'b00 → WAIT_DONE.
    - else increment the timeout counter; when it reaches CLEAR_TIMEOUT → ERROR.
  - WAIT_DONE: if Datain[1]==1 → DONE. No timeout; the timer period is up to 4e8 cycles.
  - DONE (1 cycle):
    - tick=1, tick_count+=1, led toggles.
    - next state is WRITE_START if the run latch is 1 and stop is not asserted this cycle; otherwise IDLE.
  - ERROR: error=1, busy=0. start → WRITE_START; clears error; run latch <= continuous.
- Timing:
  - Latency from start (sampled in IDLE) to WE high is 1 cycle.
  - WE is high for exactly one cycle per arm. WE is never asserted during polling.
  - The peripheral clears its control register only while WE==0; RELEASE guarantees that.
- Stale done: the peripheral resets with bit1=1. The WAIT_CLEAR-before-WAIT_DONE ordering prevents a false tick from a stale done bit.
- Datain bits other than [1:0] are ignored. X/Z on bit1 is treated as not-done.
- start while busy is ignored. stop in IDLE has no effect.
- stop asserted in any busy state clears the run latch; the current period still completes and ticks.
- tick_count wraps from 2^CNT_W-1 to 0 with no flag.
- rst asserted mid-period: immediate return to reset values. The peripheral must be reset alongside.

Test Plan:
- One-shot, 500 ms timer scaled to 20 cycles: start=1, continuous=0 → exactly one WE pulse with Dataout=1 at address 0x10C; one tick ~20+ cycles later; tick_count=1, led=1; back in IDLE with busy=0.
- Continuous, 3 periods, then stop during the 3rd period → 3 WE pulses; tick_count=3; led=1; IDLE after the 3rd tick; no 4th WE.
- Stale done right after reset: peripheral reports control=32'h2 until it clears → no tick before clear is seen; first tick only after the real expiry.
- Clear timeout: responder model holds Datain=32'h2 forever, CLEAR_TIMEOUT=16 → error=1 after 16 WAIT_CLEAR cycles; address=0; start again clears error and issues WE.
- Wrap with CNT_W=2, continuous for 5 periods → tick_count sequence 1,2,3,0,1; led toggles each tick.
- rst pulled low during WAIT_DONE → all outputs at reset values in the same cycle; no tick issued after rst is released.
